descriptor_memory_dp: RTL and testbench
=======================================

Name: descriptor_memory_dp

Overview:
- Parametrised true-dual-port descriptor RAM for the Ethernet subsystem. Two Avalon-MM slaves (s1, s2) sit between the DMA descriptor engines and the CPU.
- Improves on the fixed 32x1024 generation with:
  - configurable width and depth
  - selectable read latency with readdatavalid
  - hardware zero-clear after reset, with waitrequest
  - a defined same-address write-collision policy and a collision counter

Parameters:
DATA_W, 32, data width per port; multiple of 8
DEPTH, 1024, words; power of two, 16..65536
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
READ_LATENCY, 1, cycles from accepted read to readdata: 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear
CNT_W, 16, collision counter width

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
reset_req  in  1  freeze: while high, no write is committed and the read pipeline holds
address  in  ADDR_W  port 1 word address
chipselect  in  1  port 1 select
write  in  1  port 1 write (0 = read)
byteenable  in  DATA_W/8  port 1 byte lanes
writedata  in  DATA_W  port 1 write data
clken  in  1  port 1 request qualifier
waitrequest  out  1  port 1 stall
readdata  out  DATA_W  port 1 read data
readdatavalid  out  1  port 1 read-data strobe
address2, chipselect2, write2, byteenable2, writedata2, clken2  in  as port 1  port 2 request
waitrequest2, readdata2, readdatavalid2  out  as port 1  port 2 response
clear_busy  out  1  high while the clear sequence runs
collision_count  out  CNT_W  saturating count of same-address dual writes

Behaviour:
- Reset values:
  - waitrequest, waitrequest2 and clear_busy = CLEAR_ON_RESET
  - readdatavalid, readdatavalid2 = 0
  - readdata, readdata2 = 0
  - collision_count = 0
  - memory contents are not reset; only the clear sequence zeroes them
- FSM states: CLEAR, READY.
  - reset -> CLEAR if CLEAR_ON_RESET = 1, else READY.
  - CLEAR writes zero to word clr_ptr with all byte lanes enabled, one word per cycle, through the core's port A. clr_ptr increments 0..DEPTH-1.
  - After the write of DEPTH-1, CLEAR -> READY on the next edge. The clear takes exactly DEPTH cycles.
  - In CLEAR, waitrequest, waitrequest2 and clear_busy are all high. User requests are ignored, and no readdatavalid is produced.
  - Reset asserted during CLEAR restarts the clear with clr_ptr = 0.
  - reset_req high during CLEAR pauses clr_ptr; the clear resumes when reset_req falls.
- Request acceptance, per port: accepted = chipselect & clken & ~waitrequest & ~reset_req. In READY, waitrequest = 0.
- Write: an accepted write commits the enabled lanes at the clk edge. No readdatavalid is produced for a write.
- Read: an accepted read returns data on readdata, and readdatavalid pulses for one cycle:
  - READ_LATENCY = 1: one edge later.
  - READ_LATENCY = 2: two edges later.
- The read pipeline accepts one read per port per cycle, back to back.
- readdata holds its last value when readdatavalid is 0.
- reset_req:
  - Pipeline registers hold and readdatavalid is forced to 0.
  - The held entry emerges once reset_req falls.
  - Reads in flight are not lost.
- Read-during-write:
  - Same port: returns old data.
  - Port 1 read and port 2 write to the same address in the same cycle, or vice versa: returns old data.
- Write collision (both ports accept a write to the same address in the same cycle):
  - Lanes enabled on port 1 take port 1 data.
  - Lanes enabled only on port 2 take port 2 data.
  - collision_count increments by 1 on the following edge and saturates at 2^CNT_W-1.
  - collision_count clears only on reset.
- Address is a full ADDR_W-bit word index; there is no wrap logic. Port 2 reads have the same timing as port 1.

Decomposition:
- Package descriptor_memory_pkg holds:
  - state enum {CLEAR, READY}
  - the legal READ_LATENCY values (1, 2)
  - a byte-lane merge function that resolves collisions
- Sub-module descriptor_ram_core: inferred true-dual-port byte-enable RAM with read-before-write and 1-cycle registered output.
- The top level holds the clear FSM, collision merge, latency stage, valid pipeline and counter.
- Collision handling: the top steers the merged word into core port A and blocks port B's write, so the core never sees a dual-port write conflict.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16, reset for 1 cycle -> clear_busy and waitrequest stay high for exactly 16 cycles; afterwards a read of each of addresses 0..15 returns 0.
- Write 0xDEADBEEF to addr 5 on port 1 (byteenable 4'hF), then read addr 5 on port 2 with READ_LATENCY=2 -> readdata2 = 0xDEADBEEF and readdatavalid2 high exactly 2 cycles after acceptance.
- Same cycle: port 1 writes 0x11111111 with byteenable 4'b0011 and port 2 writes 0x22222222 with byteenable 4'b1110, both to addr 9 -> word reads 0x22221111 and collision_count = 1.
- Back-to-back port 1 reads of addrs 0,1,2,3 with reset_req pulsed high for 2 cycles mid-burst -> four valid strobes in order with correct data; no valid while reset_req is high.
- Reset asserted at clear cycle 7 -> clear restarts and clear_busy stays high for 16 further cycles.
- Preload addr 3 = 0xA5A5A5A5; port 1 reads addr 3 while port 2 writes 0x5A5A5A5A to addr 3 in the same cycle -> readdata = 0xA5A5A5A5 and a subsequent read returns 0x5A5A5A5A.

Source files
------------

// File: rtl/descriptor_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : descriptor_memory_pkg
//  Description : Shared types, constants and the collision lane-merge helper
//                for the dual-port descriptor memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package descriptor_memory_pkg;

    // Controller states: zero-clear sweep, then normal service
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Supported read latencies (accepted read to readdatavalid)
    localparam int c_READ_LATENCY_1 = 1;
    localparam int c_READ_LATENCY_2 = 2;

    // One byte lane of a same-address dual write: port 1 wins wherever it
    // enables the lane, otherwise the lane carries port 2 data.
    function automatic logic [7:0] merge_lane(
        input logic       be1,
        input logic [7:0] d1,
        input logic [7:0] d2
    );
        return be1 ? d1 : d2;
    endfunction

endpackage : descriptor_memory_pkg
`default_nettype wire

// File: rtl/descriptor_memory_dp_core.sv
`default_nettype none
// ============================================================================
//  Module      : descriptor_ram_core
//  Description : Inferred true-dual-port byte-enable RAM, read-before-write,
//                one-cycle registered read outputs with synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module descriptor_ram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_a_re,
    input  logic                i_a_we,
    input  logic [DATA_W/8-1:0] i_a_be,
    input  logic [ADDR_W-1:0]   i_a_addr,
    input  logic [DATA_W-1:0]   i_a_wdata,
    output logic [DATA_W-1:0]   o_a_rdata,
    input  logic                i_b_re,
    input  logic                i_b_we,
    input  logic [DATA_W/8-1:0] i_b_be,
    input  logic [ADDR_W-1:0]   i_b_addr,
    input  logic [DATA_W-1:0]   i_b_wdata,
    output logic [DATA_W-1:0]   o_b_rdata
);

    localparam int c_NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    // Byte-lane writes from both ports; the caller never targets one word
    // from both ports in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (i_a_we && i_a_be[i]) r_mem[i_a_addr][i*8 +: 8] <= i_a_wdata[i*8 +: 8];
            if (i_b_we && i_b_be[i]) r_mem[i_b_addr][i*8 +: 8] <= i_b_wdata[i*8 +: 8];
        end
    end

    // Registered reads sample the array before this edge's writes land,
    // giving old data on any read-during-write; outputs hold between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (i_a_re) r_a_rdata <= r_mem[i_a_addr];
            if (i_b_re) r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule : descriptor_ram_core
`default_nettype wire

// File: rtl/descriptor_memory_dp.sv
`default_nettype none
// ============================================================================
//  Module      : descriptor_memory_dp
//  Description : Dual Avalon-MM descriptor RAM with post-reset zero clear,
//                selectable read latency, write-collision merge and a
//                saturating collision counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module descriptor_memory_dp
    import descriptor_memory_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    input  logic [ADDR_W-1:0]   address2,
    input  logic                chipselect2,
    input  logic                write2,
    input  logic [DATA_W/8-1:0] byteenable2,
    input  logic [DATA_W-1:0]   writedata2,
    input  logic                clken2,
    output logic                waitrequest2,
    output logic [DATA_W-1:0]   readdata2,
    output logic                readdatavalid2,
    output logic                clear_busy,
    output logic [CNT_W-1:0]    collision_count
);

    localparam int                c_NB          = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_t            c_RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_clr_ptr;
    logic [CNT_W-1:0]   r_coll_cnt;
    logic               r_p1_vld_s1;
    logic               r_p2_vld_s1;

    logic               w_busy;
    logic               w_acc1, w_acc2;
    logic               w_wr1, w_wr2, w_rd1, w_rd2;
    logic               w_coll;
    logic [DATA_W-1:0]  w_merge_data;
    logic               w_a_we;
    logic [c_NB-1:0]    w_a_be;
    logic [ADDR_W-1:0]  w_a_addr;
    logic [DATA_W-1:0]  w_a_wdata;
    logic               w_b_we;
    logic [DATA_W-1:0]  w_a_rdata, w_b_rdata;
    logic               w_p1_vld_out, w_p2_vld_out;
    logic [DATA_W-1:0]  w_p1_dat_out, w_p2_dat_out;

    assign w_busy = (r_state == CLEAR);

    // Request qualification; reset_req freezes all user traffic
    assign w_acc1 = chipselect  & clken  & ~w_busy & ~reset_req;
    assign w_acc2 = chipselect2 & clken2 & ~w_busy & ~reset_req;
    assign w_wr1  = w_acc1 &  write;
    assign w_rd1  = w_acc1 & ~write;
    assign w_wr2  = w_acc2 &  write2;
    assign w_rd2  = w_acc2 & ~write2;
    assign w_coll = w_wr1 & w_wr2 & (address == address2);

    generate
        for (genvar g = 0; g < c_NB; g++) begin : g_merge
            assign w_merge_data[g*8 +: 8] =
                merge_lane(byteenable[g], writedata[g*8 +: 8], writedata2[g*8 +: 8]);
        end
    endgenerate

    // Clear sweep: one zero word per cycle, paused by reset_req, restarted by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_RESET_STATE;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (!reset_req) begin
                        r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                        if (r_clr_ptr == c_LAST_ADDR) r_state <= READY;
                    end
                end
                default: r_state <= READY;
            endcase
        end
    end

    // Port A carries the clear sweep, port 1 traffic, or a merged collision word
    always_comb begin
        w_a_we    = w_wr1;
        w_a_be    = byteenable;
        w_a_addr  = address;
        w_a_wdata = writedata;
        if (w_busy) begin
            w_a_we    = ~reset & ~reset_req;
            w_a_be    = '1;
            w_a_addr  = r_clr_ptr;
            w_a_wdata = '0;
        end else if (w_coll) begin
            w_a_we    = 1'b1;
            w_a_be    = byteenable | byteenable2;
            w_a_wdata = w_merge_data;
        end
    end

    // Port B's write is dropped when it has been folded into port A
    assign w_b_we = w_wr2 & ~w_coll;

    descriptor_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk       (clk),
        .rst       (reset),
        .i_a_re    (w_rd1),
        .i_a_we    (w_a_we),
        .i_a_be    (w_a_be),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_re    (w_rd2),
        .i_b_we    (w_b_we),
        .i_b_be    (byteenable2),
        .i_b_addr  (address2),
        .i_b_wdata (writedata2),
        .o_b_rdata (w_b_rdata)
    );

    // First valid stage tracks reads accepted into the core; holds under reset_req
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_vld_s1 <= 1'b0;
            r_p2_vld_s1 <= 1'b0;
        end else if (!reset_req) begin
            r_p1_vld_s1 <= w_rd1;
            r_p2_vld_s1 <= w_rd2;
        end
    end

    generate
        if (READ_LATENCY == c_READ_LATENCY_2) begin : g_lat2
            logic              r_p1_vld_s2, r_p2_vld_s2;
            logic [DATA_W-1:0] r_p1_dat_s2, r_p2_dat_s2;

            // Extra output stage; data only advances with a valid entry so it holds otherwise
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_p1_vld_s2 <= 1'b0;
                    r_p2_vld_s2 <= 1'b0;
                    r_p1_dat_s2 <= '0;
                    r_p2_dat_s2 <= '0;
                end else if (!reset_req) begin
                    r_p1_vld_s2 <= r_p1_vld_s1;
                    r_p2_vld_s2 <= r_p2_vld_s1;
                    if (r_p1_vld_s1) r_p1_dat_s2 <= w_a_rdata;
                    if (r_p2_vld_s1) r_p2_dat_s2 <= w_b_rdata;
                end
            end

            assign w_p1_vld_out = r_p1_vld_s2;
            assign w_p2_vld_out = r_p2_vld_s2;
            assign w_p1_dat_out = r_p1_dat_s2;
            assign w_p2_dat_out = r_p2_dat_s2;
        end else begin : g_lat1
            assign w_p1_vld_out = r_p1_vld_s1;
            assign w_p2_vld_out = r_p2_vld_s1;
            assign w_p1_dat_out = w_a_rdata;
            assign w_p2_dat_out = w_b_rdata;
        end
    endgenerate

    // Saturating count of same-address dual writes; cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coll_cnt <= '0;
        end else if (w_coll && (r_coll_cnt != {CNT_W{1'b1}})) begin
            r_coll_cnt <= r_coll_cnt + CNT_W'(1);
        end
    end

    assign waitrequest     = w_busy;
    assign waitrequest2    = w_busy;
    assign clear_busy      = w_busy;
    assign readdata        = w_p1_dat_out;
    assign readdata2       = w_p2_dat_out;
    assign readdatavalid   = w_p1_vld_out & ~reset_req;
    assign readdatavalid2  = w_p2_vld_out & ~reset_req;
    assign collision_count = r_coll_cnt;

endmodule : descriptor_memory_dp
`default_nettype wire

// File: tb/tb_descriptor_memory_dp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_descriptor_memory_dp
//  Description : Directed self-checking bench for descriptor_memory_dp
//                (DEPTH=16, READ_LATENCY=2, CLEAR_ON_RESET=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_descriptor_memory_dp;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset, reset_req;
    logic [AW-1:0] address, address2;
    logic          chipselect, chipselect2, write, write2, clken, clken2;
    logic [3:0]    byteenable, byteenable2;
    logic [DW-1:0] writedata, writedata2;
    logic          waitrequest, waitrequest2, readdatavalid, readdatavalid2, clear_busy;
    logic [DW-1:0] readdata, readdata2;
    logic [CW-1:0] collision_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    descriptor_memory_dp #(
        .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .address(address), .chipselect(chipselect), .write(write),
        .byteenable(byteenable), .writedata(writedata), .clken(clken),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .address2(address2), .chipselect2(chipselect2), .write2(write2),
        .byteenable2(byteenable2), .writedata2(writedata2), .clken2(clken2),
        .waitrequest2(waitrequest2), .readdata2(readdata2), .readdatavalid2(readdatavalid2),
        .clear_busy(clear_busy), .collision_count(collision_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 0; chipselect2 = 0; write = 0; write2 = 0;
        clken = 1; clken2 = 1; byteenable = 4'hF; byteenable2 = 4'hF;
        writedata = '0; writedata2 = '0; address = '0; address2 = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        if (p == 1) begin
            chipselect = 1; write = 1; address = a; writedata = d; byteenable = be;
        end else begin
            chipselect2 = 1; write2 = 1; address2 = a; writedata2 = d; byteenable2 = be;
        end
        tick();
        idle();
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        if (p == 1) begin
            chipselect = 1; write = 0; address = a;
        end else begin
            chipselect2 = 1; write2 = 0; address2 = a;
        end
        tick();
        idle();
        tick();
        if (p == 1) begin
            chk({tag, "_vld"}, readdatavalid, 1);
            chk({tag, "_data"}, readdata, exp);
        end else begin
            chk({tag, "_vld"}, readdatavalid2, 1);
            chk({tag, "_data"}, readdata2, exp);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (clear_busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    logic [DW-1:0] burst_q[$];
    int            nbusy;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1; reset_req = 0;
        tick();
        tick();
        reset = 0;

        // Reset values
        chk("rst_waitreq",   waitrequest, 1);
        chk("rst_waitreq2",  waitrequest2, 1);
        chk("rst_busy",      clear_busy, 1);
        chk("rst_rdv",       readdatavalid, 0);
        chk("rst_rdv2",      readdatavalid2, 0);
        chk("rst_rdata",     readdata, 0);
        chk("rst_rdata2",    readdata2, 0);
        chk("rst_collcnt",   collision_count, 0);

        // Clear lasts exactly DEPTH cycles, then all words read zero
        count_busy(nbusy);
        chk("clr_cycles", nbusy, 16);
        chk("clr_waitreq_low", waitrequest, 0);
        for (int i = 0; i < DEPTH; i++) rd(1, AW'(i), 32'h0, $sformatf("clr_rd%0d", i));

        // Port 1 write, port 2 read with 2-cycle latency
        wr(1, 4'd5, 32'hDEADBEEF, 4'hF);
        chipselect2 = 1; write2 = 0; address2 = 4'd5;
        tick();
        idle();
        chk("p2_lat_edge1_vld", readdatavalid2, 0);
        tick();
        chk("p2_lat_edge2_vld", readdatavalid2, 1);
        chk("p2_lat_data", readdata2, 32'hDEADBEEF);
        tick();
        chk("p2_lat_edge3_vld", readdatavalid2, 0);
        chk("p2_hold_data", readdata2, 32'hDEADBEEF);

        // Same-address dual write
        chk("coll_cnt_before", collision_count, 0);
        chipselect = 1; write = 1; address = 4'd9; writedata = 32'h11111111; byteenable = 4'b0011;
        chipselect2 = 1; write2 = 1; address2 = 4'd9; writedata2 = 32'h22222222; byteenable2 = 4'b1110;
        tick();
        idle();
        chk("coll_cnt_after", collision_count, 1);
        rd(1, 4'd9, 32'h22221111, "coll_word");

        // Back-to-back reads with a 2-cycle freeze mid-burst
        for (int i = 0; i < 4; i++) wr(2, AW'(i), 32'hC0DE0000 | i, 4'hF);
        burst_q.delete();
        fork
            begin
                chipselect = 1; write = 0; address = 4'd0;
                tick();
                address = 4'd1;
                tick();
                address = 4'd2; reset_req = 1;
                tick();
                tick();
                reset_req = 0;
                tick();
                address = 4'd3;
                tick();
                idle();
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    chk($sformatf("burst_frz_vld%0d", c), readdatavalid & reset_req, 0);
                    if (readdatavalid) burst_q.push_back(readdata);
                end
            end
        join
        chk("burst_count", burst_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < burst_q.size()) chk($sformatf("burst_data%0d", i), burst_q[i], 32'hC0DE0000 | i);
        end

        // Cross-port read-during-write returns old data
        wr(1, 4'd3, 32'hA5A5A5A5, 4'hF);
        chipselect = 1; write = 0; address = 4'd3;
        chipselect2 = 1; write2 = 1; address2 = 4'd3; writedata2 = 32'h5A5A5A5A; byteenable2 = 4'hF;
        tick();
        idle();
        tick();
        chk("rdw_vld", readdatavalid, 1);
        chk("rdw_old", readdata, 32'hA5A5A5A5);
        rd(1, 4'd3, 32'h5A5A5A5A, "rdw_new");

        // Reset during clear cycle 7 restarts the full sweep
        reset = 1;
        tick();
        reset = 0;
        repeat (7) tick();
        chk("restart_busy_c7", clear_busy, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("restart_collcnt", collision_count, 0);
        count_busy(nbusy);
        chk("restart_cycles", nbusy, 16);
        rd(2, 4'd3, 32'h0, "restart_rd3");
        rd(1, 4'd9, 32'h0, "restart_rd9");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_descriptor_memory_dp
`default_nettype wire
